nibble_rx: RTL
==============

Name: nibble_rx

Overview:
- Serial-to-parallel front end that feeds the 4-bit registered data stage.
- Recovers 4-bit frames from an asynchronous single-wire serial line (idle-high, start bit, 4 data bits LSB first, stop bit).
- Presents each good nibble on a 4-bit bus with a one-cycle load strobe that drives the downstream stage's enable input directly.

Parameters:
- CLKS_PER_BIT, 4: clk cycles per serial bit. Must be even and >= 2.
- CNT_W, $clog2(CLKS_PER_BIT)+1: width of the bit-period counter. Derived; do not override.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- rx  input  1  serial line, idle high, asynchronous to clk.
- data  output  4  last good nibble received.
- enable  output  1  one-cycle strobe; high for exactly one cycle when data is updated.
- busy  output  1  high whenever the FSM is not in IDLE.
- frame_err  output  1  one-cycle strobe when the stop bit samples low.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (rst_n), clock is clk. While rst_n=0:
  - data=4'h0, enable=0, busy=0, frame_err=0.
  - Synchronizer flops=1, shift register=0, counter=0, bit index=0, FSM=IDLE.
  - Reset asserted mid-frame aborts the frame immediately; no strobe is produced.
- Input sync: rx passes through 2 flops (reset to 1) giving rx_s. All decisions use rx_s only.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE (plus PARITY when the optional feature is enabled).
- IDLE: when rx_s=0, go to START with cnt=0.
- START: cnt increments each cycle. At cnt=CLKS_PER_BIT/2-1, sample rx_s:
  - rx_s=0: go to DATA with cnt=0, idx=0.
  - rx_s=1: glitch; return to IDLE with no strobe.
- DATA: at cnt=CLKS_PER_BIT-1, shreg[idx]<=rx_s and cnt<=0. After idx=3, go to STOP; otherwise idx<=idx+1.
- STOP: at cnt=CLKS_PER_BIT-1, sample rx_s:
  - rx_s=1: data<=shreg, enable<=1 for the next cycle only, then return to IDLE.
  - rx_s=0: frame_err<=1 for one cycle, data unchanged, go to WAIT_IDLE.
- WAIT_IDLE: stay until rx_s=1, then go to IDLE. This prevents a held-low break from retriggering.
- Hold rules: enable and frame_err are never high simultaneously. data holds its value between good frames. enable is never high for 2 consecutive cycles.
- Latency: with CLKS_PER_BIT=N, enable rises 2 + N/2 + 5N (+/-1) cycles after the rx falling edge.
- Back-to-back frames: a start bit arriving the cycle after STOP completes is accepted; no idle gap is required beyond the stop bit.
- Counters wrap only by explicit clear. No free-running overflow is permitted.

Optional Feature:
- Macro: NIBBLE_RX_PARITY_EN.
- Defined:
  - An even-parity bit follows data bit 3; the FSM goes DATA -> PARITY -> STOP.
  - PARITY samples at cnt=CLKS_PER_BIT-1 and computes err = ^shreg ^ rx_s.
  - Extra output port parity_err (1 bit, reset 0).
  - On a valid stop bit with err=1: parity_err pulses one cycle, enable stays 0, data is unchanged.
- Undefined: no PARITY state, no parity_err port; frame format is exactly 6 bits.

Test Plan:
- Reset: hold rst_n=0 with rx toggling -> data=0, enable=0, busy=0, frame_err=0 throughout.
- Good frame (N=4): send start, bits 1,0,1,1, stop=1 -> enable high exactly 1 cycle, data=4'hD, busy falls after the strobe.
- Glitch: rx low for 1 bit-cycle less than N/2 -> FSM returns to IDLE, no enable, no frame_err, data unchanged.
- Framing error: send 4'h6 with stop=0, then hold rx low 3N cycles -> frame_err pulses once, data keeps its previous value, no re-trigger until rx returns high.
- Back-to-back: frames 4'hA then 4'h5 with no idle gap -> two enable pulses, data=4'hA then 4'h5.
- Mid-frame reset: drop rst_n during DATA bit 2 -> all outputs clear asynchronously; the frame after release decodes correctly. With NIBBLE_RX_PARITY_EN, a wrong parity on 4'h3 -> parity_err=1, enable=0.

Source files
------------

// File: rtl/nibble_rx.sv
// nibble_rx: oversampling receiver for idle-high serial frames (start, 4 data bits LSB first, stop).
// Optional build macro NIBBLE_RX_PARITY_EN inserts an even-parity bit before the stop bit and adds parity_err.
module nibble_rx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT) + 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [3:0] data,
    output logic       enable,
    output logic       busy,
    output logic       frame_err
`ifdef NIBBLE_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
`ifdef NIBBLE_RX_PARITY_EN
        ,
        PARITY    = 3'd5
`endif
    } state_t;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [1:0]       sync_q;
    logic             rx_s;
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       idx_q;
    logic [3:0]       shreg_q;
    logic [3:0]       data_q;
    logic             enable_q;
    logic             busy_q;
    logic             frame_err_q;
`ifdef NIBBLE_RX_PARITY_EN
    logic             par_bad_q;
    logic             parity_err_q;

    // Even parity: the four data bits plus the parity bit must hold an even number of ones.
    function automatic logic parity_mismatch(input logic [3:0] nib, input logic par);
        return (^nib) ^ par;
    endfunction
`endif

    assign rx_s      = sync_q[1];
    assign data      = data_q;
    assign enable    = enable_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;
`ifdef NIBBLE_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

    // Two-flop synchronizer for the asynchronous serial line; resets to the idle level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx};
        end
    end

    // Receive FSM with registered strobes, data and busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= 2'd0;
            shreg_q     <= 4'h0;
            data_q      <= 4'h0;
            enable_q    <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef NIBBLE_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            enable_q    <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef NIBBLE_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (!rx_s) begin
                        state_q <= START;
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q <= '0;
                        if (!rx_s) begin
                            state_q <= DATA;
                            idx_q   <= 2'd0;
                        end else begin
                            // Line went back high before mid-start-bit: treat as a glitch.
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q          <= '0;
                        shreg_q[idx_q] <= rx_s;
                        if (idx_q == 2'd3) begin
`ifdef NIBBLE_RX_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end else begin
                            idx_q <= idx_q + 2'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
`ifdef NIBBLE_RX_PARITY_EN
                PARITY: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q     <= '0;
                        par_bad_q <= parity_mismatch(shreg_q, rx_s);
                        state_q   <= STOP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
`endif
                STOP: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q <= '0;
                        if (rx_s) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
`ifdef NIBBLE_RX_PARITY_EN
                            if (par_bad_q) begin
                                parity_err_q <= 1'b1;
                            end else begin
                                data_q   <= shreg_q;
                                enable_q <= 1'b1;
                            end
`else
                            data_q   <= shreg_q;
                            enable_q <= 1'b1;
`endif
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= WAIT_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                WAIT_IDLE: begin
                    // A held-low break must return high before a new start bit is honoured.
                    cnt_q <= '0;
                    if (rx_s) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        busy_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    idx_q   <= 2'd0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
